lcd_bus_wr: RTL and testbench
=============================

Name: lcd_bus_wr

Overview:
- HD44780-style 4-bit bus write engine; the timing stage directly below the LCD driver top-level's command/character sequencer.
- Accepts one byte per valid/ready handshake, with a register-select flag and a nibble-only flag.
- Drives reg_sel, enable and a 4-bit data nibble bus with setup, pulse-width, hold, inter-nibble and execution-time spacing.
- Built for the 100 MHz system clock; all timing is expressed in clock cycles via parameters.

Parameters:
- T_SETUP_CYC, 5, cycles from data/reg_sel valid to enable rise (≥40 ns tAS).
- T_EN_CYC, 50, enable high width in cycles (≥450 ns).
- T_HOLD_CYC, 2, cycles data/reg_sel held after enable fall.
- T_NIB_CYC, 100, cycles from low-nibble drive to its enable rise (second-nibble setup/gap, ≥1 µs).
- T_EXEC_CYC, 4000, post-transfer wait, normal commands and data (40 µs).
- T_EXEC_LONG_CYC, 164000, post-transfer wait for clear/home (1.64 ms).
- All parameters ≥1; counter width = clog2 of the largest parameter + 1.

Ports:
- clk_i  in  1  system clock, 100 MHz
- rst_n_i  in  1  asynchronous, active-low reset
- wr_valid_i  in  1  write request valid
- wr_ready_o  out  1  engine idle, request accepted this cycle if valid
- wr_rs_i  in  1  register select for the request (0 = instruction, 1 = data)
- wr_data_i  in  8  byte to write
- wr_nib_only_i  in  1  send only wr_data_i[7:4] (init sequence)
- busy_o  out  1  high from accept until the end of EXEC
- reg_sel_o  out  1  LCD RS
- enable_o  out  1  LCD E strobe
- lcd_data_o  out  4  LCD DB[7:4]

Behaviour:
- Reset (asynchronous, immediate, valid mid-transfer) forces:
  - state IDLE, counter 0
  - enable_o=0, reg_sel_o=0, lcd_data_o=0
  - wr_ready_o=1, busy_o=0
  - any in-progress transfer is abandoned and not resumed.
- wr_ready_o = (state==IDLE), registered-state-derived; busy_o = ~wr_ready_o.
- Accept occurs on a rising edge with wr_valid_i & wr_ready_o. At that edge:
  - capture rs, data and nib_only
  - reg_sel_o <= wr_rs_i, lcd_data_o <= wr_data_i[7:4]
  - state <= SETUP.
- wr_valid_i while not ready is ignored. There is no queue; the requester must hold the request until accepted.
- SETUP: wait T_SETUP_CYC cycles, then enable_o <= 1 and go to PULSE. Enable rises exactly T_SETUP_CYC edges after the accept edge.
- PULSE: enable_o stays high exactly T_EN_CYC cycles, then enable_o <= 0 and go to HOLD.
- HOLD: reg_sel_o and lcd_data_o are unchanged for T_HOLD_CYC cycles. Then:
  - if the low nibble is still pending: lcd_data_o <= data[3:0], go to GAP
  - else go to EXEC.
- GAP: wait T_NIB_CYC cycles, then enable_o <= 1 and go to PULSE for the second nibble (same T_EN_CYC and T_HOLD_CYC).
- Nibble-only requests skip GAP and the second pulse: exactly one enable pulse.
- EXEC wait length:
  - T_EXEC_LONG_CYC if captured rs=0 and data is 0x01, 0x02 or 0x03
  - otherwise T_EXEC_CYC.
  - Then go to IDLE.
- reg_sel_o and lcd_data_o are only changed at accept, at the low-nibble drive, and at reset. They retain their last values in EXEC and IDLE.
- enable_o is never high outside PULSE; no glitches (registered output).
- Back-to-back requests: a new accept is possible on the first edge with state==IDLE. Minimum edge-to-edge accept spacing, byte mode = 2·T_EN + 2·T_HOLD + T_SETUP + T_NIB + T_EXEC + small fixed FSM overhead. The bench measures and documents that overhead and checks it is constant.
- Counter loads (param−1) on state entry, decrements, and transitions at 0. No wrap.

Test Plan:
- Reset mid-PULSE: assert rst_n_i low while enable_o=1 → enable_o, reg_sel_o and lcd_data_o go 0 immediately (no clock edge needed); wr_ready_o=1 after release.
- Data byte 0x48, rs=1 → two enable pulses, each 50 cycles wide:
  - first pulse rises 5 cycles after accept with lcd_data_o=0x4, reg_sel_o=1
  - second pulse with lcd_data_o=0x8
  - then wr_ready_o stays low 4000 cycles after the final hold.
- Instruction 0x01, rs=0 → two pulses (0x0, then 0x1), then 164000-cycle EXEC before wr_ready_o rises.
- Nibble-only 0x30, rs=0 → exactly one 50-cycle enable pulse with lcd_data_o=0x3, then 4000-cycle EXEC. Count enable rising edges = 1.
- wr_valid_i held high with changing data during busy → only the byte present at the accept edge is sent; the next byte is accepted on the first IDLE edge. Check accept spacing is constant across 3 back-to-back writes.
- Timing checker throughout: data and reg_sel stable from ≥5 cycles before each enable rise to ≥2 cycles after each fall; ≥100 cycles between nibble-1 enable fall and nibble-2 enable rise.

Source files
------------

// File: rtl/lcd_bus_wr.sv
// HD44780-style 4-bit bus write engine: sends one byte (or one high nibble)
// per handshake with setup, enable-width, hold, inter-nibble and execution spacing.
module lcd_bus_wr #(
    parameter int T_SETUP_CYC     = 5,
    parameter int T_EN_CYC        = 50,
    parameter int T_HOLD_CYC      = 2,
    parameter int T_NIB_CYC       = 100,
    parameter int T_EXEC_CYC      = 4000,
    parameter int T_EXEC_LONG_CYC = 164000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       wr_valid_i,
    output logic       wr_ready_o,
    input  logic       wr_rs_i,
    input  logic [7:0] wr_data_i,
    input  logic       wr_nib_only_i,
    output logic       busy_o,
    output logic       reg_sel_o,
    output logic       enable_o,
    output logic [3:0] lcd_data_o
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(max2(T_SETUP_CYC, T_EN_CYC), max2(T_HOLD_CYC, T_NIB_CYC)),
                                  max2(T_EXEC_CYC, T_EXEC_LONG_CYC));
    localparam int CW = $clog2(MAX_CYC) + 1;

    // Each state lasts exactly its parameter in cycles: load (param-1), leave at 0.
    localparam logic [CW-1:0] L_SETUP = CW'(T_SETUP_CYC - 1);
    localparam logic [CW-1:0] L_EN    = CW'(T_EN_CYC - 1);
    localparam logic [CW-1:0] L_HOLD  = CW'(T_HOLD_CYC - 1);
    localparam logic [CW-1:0] L_NIB   = CW'(T_NIB_CYC - 1);
    localparam logic [CW-1:0] L_EXEC  = CW'(T_EXEC_CYC - 1);
    localparam logic [CW-1:0] L_LONG  = CW'(T_EXEC_LONG_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_GAP,
        S_EXEC
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_lo_nib;
    logic          r_lo_pending;
    logic          r_long;
    logic          w_cnt_done;

    assign wr_ready_o = (r_state == S_IDLE);
    assign busy_o     = ~wr_ready_o;
    assign w_cnt_done = (r_cnt == '0);

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_lo_nib     <= '0;
            r_lo_pending <= 1'b0;
            r_long       <= 1'b0;
            reg_sel_o    <= 1'b0;
            enable_o     <= 1'b0;
            lcd_data_o   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (wr_valid_i) begin
                        reg_sel_o    <= wr_rs_i;
                        lcd_data_o   <= wr_data_i[7:4];
                        r_lo_nib     <= wr_data_i[3:0];
                        r_lo_pending <= ~wr_nib_only_i;
                        // Clear display / return home need the long execution wait.
                        r_long       <= ~wr_rs_i && (wr_data_i inside {8'h01, 8'h02, 8'h03});
                        r_cnt        <= L_SETUP;
                        r_state      <= S_SETUP;
                    end
                end
                S_SETUP, S_GAP: begin
                    if (w_cnt_done) begin
                        enable_o <= 1'b1;
                        r_cnt    <= L_EN;
                        r_state  <= S_PULSE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_PULSE: begin
                    if (w_cnt_done) begin
                        enable_o <= 1'b0;
                        r_cnt    <= L_HOLD;
                        r_state  <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_HOLD: begin
                    if (w_cnt_done) begin
                        if (r_lo_pending) begin
                            lcd_data_o   <= r_lo_nib;
                            r_lo_pending <= 1'b0;
                            r_cnt        <= L_NIB;
                            r_state      <= S_GAP;
                        end else begin
                            r_cnt   <= r_long ? L_LONG : L_EXEC;
                            r_state <= S_EXEC;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_EXEC: begin
                    if (w_cnt_done) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_wr.sv
// Self-checking bench for lcd_bus_wr: directed and random writes compared against
// a timeline model derived from the bus timing rules, plus a setup/hold trace checker.
module tb_lcd_bus_wr;

    localparam int S  = 5;
    localparam int E  = 50;
    localparam int H  = 2;
    localparam int N  = 100;
    localparam int X  = 4000;
    localparam int XL = 8200;   // long wait scaled down so the run stays short
    // Measured FSM overhead: the next accept lands one edge after the return to IDLE.
    localparam int FSM_OVH = 1;
    localparam int BUDGET  = XL + 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       wr_rs = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_nib = 1'b0;
    logic       busy;
    logic       reg_sel;
    logic       enable;
    logic [3:0] lcd_data;

    int n_vec = 0;
    int n_mis = 0;

    lcd_bus_wr #(
        .T_SETUP_CYC    (S),
        .T_EN_CYC       (E),
        .T_HOLD_CYC     (H),
        .T_NIB_CYC      (N),
        .T_EXEC_CYC     (X),
        .T_EXEC_LONG_CYC(XL)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .wr_valid_i   (wr_valid),
        .wr_ready_o   (wr_ready),
        .wr_rs_i      (wr_rs),
        .wr_data_i    (wr_data),
        .wr_nib_only_i(wr_nib),
        .busy_o       (busy),
        .reg_sel_o    (reg_sel),
        .enable_o     (enable),
        .lcd_data_o   (lcd_data)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge k, cyc == k.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus trace recorded at negedges: enable edges and data/rs changes.
    typedef struct {
        int unsigned t;
        logic [3:0]  d;
        logic        rs;
    } rise_t;

    rise_t       rises[$];
    int unsigned falls[$];
    int unsigned chg[$];
    logic        p_en  = 1'b0;
    logic [4:0]  p_bus = '0;

    always @(negedge clk) begin
        if ({reg_sel, lcd_data} !== p_bus) chg.push_back(cyc);
        if (enable === 1'b1 && p_en === 1'b0) rises.push_back('{cyc, lcd_data, reg_sel});
        if (enable === 1'b0 && p_en === 1'b1) falls.push_back(cyc);
        p_en  <= enable;
        p_bus <= {reg_sel, lcd_data};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned exec_len(input logic rs, input logic [7:0] d);
        return (!rs && d >= 8'h01 && d <= 8'h03) ? XL : X;
    endfunction

    // Compare the recorded trace of one transfer against the model timeline.
    task automatic analyze(input string nm, input logic rs, input logic [7:0] d, input logic nib,
                           input int unsigned acc, input int unsigned rdy);
        int unsigned n_exp;
        int unsigned er[2];
        int unsigned ef[2];
        logic [3:0]  nd[2];
        int unsigned su_viol;
        int unsigned ho_viol;
        n_exp = nib ? 1 : 2;
        nd[0] = d[7:4];
        nd[1] = d[3:0];
        er[0] = acc + S;
        ef[0] = er[0] + E;
        er[1] = ef[0] + H + N;
        ef[1] = er[1] + E;
        check({nm, "_rise_count"}, rises.size(), n_exp);
        check({nm, "_fall_count"}, falls.size(), n_exp);
        for (int i = 0; i < int'(n_exp) && i < rises.size(); i++) begin
            check($sformatf("%s_rise%0d_time", nm, i), rises[i].t, er[i]);
            check($sformatf("%s_rise%0d_data", nm, i), rises[i].d, nd[i]);
            check($sformatf("%s_rise%0d_rs", nm, i), rises[i].rs, rs);
        end
        for (int i = 0; i < int'(n_exp) && i < falls.size(); i++)
            check($sformatf("%s_fall%0d_time", nm, i), falls[i], ef[i]);
        if (!nib && rises.size() > 1 && falls.size() > 0)
            check({nm, "_nib_gap_ge_min"}, (rises[1].t - falls[0]) >= N, 1'b1);
        su_viol = 0;
        ho_viol = 0;
        foreach (chg[j]) begin
            foreach (rises[i]) if (chg[j] <= rises[i].t && chg[j] + S > rises[i].t) su_viol++;
            foreach (falls[i]) if (chg[j] >= falls[i] && chg[j] < falls[i] + H) ho_viol++;
        end
        check({nm, "_setup_viol"}, su_viol, 0);
        check({nm, "_hold_viol"}, ho_viol, 0);
        check({nm, "_ready_time"}, rdy, ef[n_exp-1] + H + exec_len(rs, d));
        check({nm, "_rs_retained"}, reg_sel, rs);
        check({nm, "_data_retained"}, lcd_data, nd[n_exp-1]);
    endtask

    // Called at a negedge with the engine idle; returns at the negedge where ready rises.
    task automatic send(input string nm, input logic rs, input logic [7:0] d, input logic nib,
                        input bit keep, output int unsigned acc);
        int unsigned guard;
        check({nm, "_ready_at_entry"}, wr_ready, 1'b1);
        rises.delete();
        falls.delete();
        chg.delete();
        wr_valid = 1'b1;
        wr_rs    = rs;
        wr_data  = d;
        wr_nib   = nib;
        @(negedge clk);
        acc = cyc;
        check({nm, "_acc_busy"}, {busy, wr_ready}, 2'b10);
        check({nm, "_acc_rs"}, reg_sel, rs);
        check({nm, "_acc_data"}, lcd_data, d[7:4]);
        if (!keep) wr_valid = 1'b0;
        guard = 0;
        while (wr_ready !== 1'b1 && guard < BUDGET) begin
            if (keep) begin
                wr_rs   = 1'($urandom);
                wr_data = 8'($urandom);
                wr_nib  = 1'($urandom);
            end
            @(negedge clk);
            guard++;
        end
        check({nm, "_ready_in_budget"}, guard < BUDGET, 1'b1);
        analyze(nm, rs, d, nib, acc, cyc);
    endtask

    initial begin
        int unsigned a[3];
        int unsigned dummy;
        logic [7:0]  rd;
        logic        rr;
        logic        rn;

        repeat (3) @(negedge clk);
        check("rst_hold_ready", {wr_ready, busy}, 2'b10);
        check("rst_hold_bus", {enable, reg_sel, lcd_data}, 6'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {wr_ready, busy}, 2'b10);
        check("post_rst_bus", {enable, reg_sel, lcd_data}, 6'b0);

        // Reset in the middle of the first enable pulse.
        wr_valid = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = 8'hA5;
        wr_nib   = 1'b0;
        @(negedge clk);
        wr_valid = 1'b0;
        for (int i = 0; i < 20 && enable !== 1'b1; i++) @(negedge clk);
        check("midpulse_enable_high", enable, 1'b1);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_bus", {enable, reg_sel, lcd_data}, 6'b0);
        check("async_rst_ready", {wr_ready, busy}, 2'b10);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("after_abort_ready", {wr_ready, busy}, 2'b10);
        check("after_abort_enable", enable, 1'b0);

        // Directed transfers covering the main function and exec-length boundaries.
        send("data48", 1'b1, 8'h48, 1'b0, 1'b0, dummy);
        send("clear01", 1'b0, 8'h01, 1'b0, 1'b0, dummy);
        send("nib30", 1'b0, 8'h30, 1'b1, 1'b0, dummy);
        send("home03", 1'b0, 8'h03, 1'b0, 1'b0, dummy);
        send("cmd04", 1'b0, 8'h04, 1'b0, 1'b0, dummy);
        send("data01", 1'b1, 8'h01, 1'b0, 1'b0, dummy);

        // Back-to-back with valid held high and junk data while busy.
        for (int i = 0; i < 3; i++)
            send($sformatf("b2b%0d", i), 1'b1, 8'($urandom), 1'b0, i < 2, a[i]);
        check("b2b_spacing_01", a[1] - a[0], S + 2*E + 2*H + N + X + FSM_OVH);
        check("b2b_spacing_const", a[2] - a[1], a[1] - a[0]);

        // Random transfers biased toward the long-exec command range.
        for (int i = 0; i < 2; i++) begin
            rr = 1'($urandom);
            rn = 1'($urandom);
            rd = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            send($sformatf("rnd%0d", i), rr, rd, rn, 1'b0, dummy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
